// File: rtl/fmul_pkg.sv
// Shared constants and types for the fmul result retirement stage.
package fmul_pkg;
  localparam int STATUS_W = 5;
  localparam int ST_NV = 4;
  localparam int ST_DZ = 3;
  localparam int ST_OF = 2;
  localparam int ST_UF = 1;
  localparam int ST_NX = 0;

  typedef logic [STATUS_W-1:0] fmul_status_t;
endpackage

// File: rtl/fmul_res_fifo.sv
// Result FIFO: DEPTH entries of {res, status}. The head is read straight from storage.
module fmul_res_fifo
  import fmul_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       push_res,
  input  fmul_status_t       push_status,
  input  logic               pop,
  output logic               out_valid,
  output logic [W-1:0]       out_res,
  output fmul_status_t       out_status,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [W-1:0] res;
    fmul_status_t status;
  } fmul_entry_t;

  fmul_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             full, wr, rd;

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  // A push into a full FIFO is dropped rather than overwriting the head.
  assign wr        = push & ~full;
  assign rd        = pop & out_valid;
  assign out_res    = mem[rptr].res;
  assign out_status = mem[rptr].status;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= '{res: push_res, status: push_status};
        wptr      <= wptr + PTR_W'(1);
      end
      if (rd) rptr <= rptr + PTR_W'(1);
      case ({wr, rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/fmul_result_buf.sv
// Retirement stage for mul_top: valid tracking, credit-based issue gating, result FIFO.
// FMUL_FFLAGS_ACC_EN enables the sticky exception flag accumulator.
module fmul_result_buf
  import fmul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LAT    = 3,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [EXPO_W+MANT_W:0]    mul_res,
  input  logic [STATUS_W-1:0]       mul_status,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXPO_W+MANT_W:0]    out_res,
  output logic [STATUS_W-1:0]       out_status,
  output logic [STATUS_W-1:0]       fflags,
  input  logic                      fflags_clr
);
  localparam int W     = EXPO_W + MANT_W + 1;
  localparam int IF_W  = $clog2(LAT+1);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;

  logic [LAT-1:0]   vld_pipe;
  logic [IF_W-1:0]  inflight;
  logic [CNT_W-1:0] count;
  logic             accept, arrive, pop;

  assign accept = issue_valid & issue_ready;
  assign arrive = vld_pipe[LAT-1];
  assign pop    = out_valid & out_ready;

  // Slots already committed (buffered or in the pipe) must leave room for every issue.
  assign issue_ready = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);

  generate
    if (LAT == 1) begin : g_pipe1
      always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= accept;
      end
    end else begin : g_pipeN
      always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[LAT-2:0], accept};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else begin
      case ({accept, arrive})
        2'b10:   inflight <= inflight + IF_W'(1);
        2'b01:   inflight <= inflight - IF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  fmul_res_fifo #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (arrive),
    .push_res    (mul_res),
    .push_status (mul_status),
    .pop         (pop),
    .out_valid   (out_valid),
    .out_res     (out_res),
    .out_status  (out_status),
    .count       (count)
  );

`ifdef FMUL_FFLAGS_ACC_EN
  always_ff @(posedge clk) begin
    if (rst) fflags <= '0;
    else     fflags <= (fflags_clr ? '0 : fflags) | (pop ? out_status : '0);
  end
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr;
  assign fflags = '0;
`endif

  a_issue_credit: assert property (@(posedge clk) disable iff (rst) issue_valid |-> issue_ready);
endmodule
